pic_aux_gpio: RTL and testbench

Parametrised aux-bus GPIO peripheral for the risc16f84 PIC core. It replaces the single negedge-latched IO write register that drives USER_LED with up to 8 read-back output ports and up to 8 synchronised input ports. Each input port has per-bit rising-edge capture and a maskable interrupt. It sits on the PIC auxiliary bus (aux_adr/aux_dat/aux_we/aux_re) and uses separate data-out and output-enable instead of a tri-state bus.

---
 rtl/pic_aux_gpio.sv | 161 ++++++++++++++++
 tb/tb_pic_aux_gpio.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_aux_gpio.sv
// pic_aux_gpio: aux-bus GPIO peripheral for the risc16f84 PIC core.
// Provides N_OUT read-back output ports and N_IN synchronised input ports in a
// 32-byte window at BASE_ADDR:
//   0x00+k OUT[k]  0x08+k IN[k]  0x10+k FLAG[k] (W1C)  0x18+k MASK[k]
// Build option: define AUX_GPIO_EDGE_EN to include rising-edge flags, masks
// and irq_o. Without it, offsets 0x10-0x1F read zero and irq_o is tied low.

module pic_aux_gpio #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned N_OUT     = 1,
    parameter int unsigned N_IN      = 1,
    parameter logic [7:0]  OUT_RESET = 8'h00
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_i,
    input  logic [15:0]       aux_adr_i,
    input  logic [7:0]        aux_dat_i,
    input  logic              aux_we_i,
    input  logic              aux_re_i,
    output logic [7:0]        aux_dat_o,
    output logic              aux_dat_oe_o,
    input  logic [8*N_IN-1:0] port_i,
    output logic [8*N_OUT-1:0] port_o,
    output logic              irq_o
);

    localparam int unsigned OW = 8 * N_OUT;
    localparam int unsigned IW = 8 * N_IN;

    logic          w_hit;
    logic [1:0]    w_grp;
    logic [2:0]    w_idx;
    logic          w_wr;
    logic [7:0]    w_rdata;
    logic [OW-1:0] w_out_d;
    logic [OW-1:0] r_out;
    logic [IW-1:0] r_s1;
    logic [IW-1:0] r_s2;

    // Address decode: window hit, register group (offset[4:3]) and port index
    assign w_hit = (aux_adr_i[15:5] == BASE_ADDR[15:5]);
    assign w_grp = aux_adr_i[4:3];
    assign w_idx = aux_adr_i[2:0];
    assign w_wr  = w_hit & aux_we_i & clk_en_i;

    // Next value of the output ports; indices at or above N_OUT never match
    always_comb begin
        w_out_d = r_out;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (w_wr && (w_grp == 2'd0) && (w_idx == 3'(k))) begin
                w_out_d[8*k +: 8] = aux_dat_i;
            end
        end
    end

    // Output port registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_out <= {N_OUT{OUT_RESET}};
        end else begin
            r_out <= w_out_d;
        end
    end

    assign port_o = r_out;

    // Two-flop synchroniser; free-running, not gated by clk_en_i
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= port_i;
            r_s2 <= r_s1;
        end
    end

`ifdef AUX_GPIO_EDGE_EN
    logic [IW-1:0] r_s3;
    logic [IW-1:0] r_flag;
    logic [IW-1:0] r_mask;
    logic [IW-1:0] w_rise;
    logic [IW-1:0] w_clr;
    logic [IW-1:0] w_flag_d;
    logic [IW-1:0] w_mask_d;

    // Decode W1C clears and mask loads for each input port
    always_comb begin
        w_clr    = '0;
        w_mask_d = r_mask;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (w_wr && (w_idx == 3'(k))) begin
                if (w_grp == 2'd2) begin
                    w_clr[8*k +: 8] = aux_dat_i;
                end
                if (w_grp == 2'd3) begin
                    w_mask_d[8*k +: 8] = aux_dat_i;
                end
            end
        end
    end

    // A new rising edge is OR-ed in after the clear, so set beats clear
    assign w_rise   = r_s2 & ~r_s3;
    assign w_flag_d = (r_flag & ~w_clr) | w_rise;

    // Edge detector history, flags and masks
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s3   <= '0;
            r_flag <= '0;
            r_mask <= '0;
        end else begin
            r_s3   <= r_s2;
            r_flag <= w_flag_d;
            r_mask <= w_mask_d;
        end
    end

    assign irq_o = |(r_flag & r_mask);
`else
    assign irq_o = 1'b0;
`endif

    // Combinational read mux; reads have no side effects
    always_comb begin
        w_rdata = 8'h00;
        if (w_hit) begin
            case (w_grp)
                2'd0: begin
                    for (int unsigned k = 0; k < N_OUT; k++) begin
                        if (w_idx == 3'(k)) w_rdata = r_out[8*k +: 8];
                    end
                end
                2'd1: begin
                    for (int unsigned k = 0; k < N_IN; k++) begin
                        if (w_idx == 3'(k)) w_rdata = r_s2[8*k +: 8];
                    end
                end
`ifdef AUX_GPIO_EDGE_EN
                2'd2: begin
                    for (int unsigned k = 0; k < N_IN; k++) begin
                        if (w_idx == 3'(k)) w_rdata = r_flag[8*k +: 8];
                    end
                end
                2'd3: begin
                    for (int unsigned k = 0; k < N_IN; k++) begin
                        if (w_idx == 3'(k)) w_rdata = r_mask[8*k +: 8];
                    end
                end
`endif
                default: w_rdata = 8'h00;
            endcase
        end
    end

    assign aux_dat_o    = w_rdata;
    assign aux_dat_oe_o = aux_re_i & w_hit;

endmodule

// File: tb/tb_pic_aux_gpio.sv
// Directed bench for pic_aux_gpio: BASE_ADDR=0x0020, N_OUT=2, N_IN=1,
// OUT_RESET=0xA5. Edge/interrupt checks follow the AUX_GPIO_EDGE_EN build.

module tb_pic_aux_gpio;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [15:0] aux_adr;
    logic [7:0]  aux_dat;
    logic        aux_we;
    logic        aux_re;
    logic [7:0]  aux_dat_o;
    logic        aux_dat_oe;
    logic [7:0]  port_i;
    logic [15:0] port_o;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rd;
    logic       oe;

    pic_aux_gpio #(
        .BASE_ADDR(16'h0020),
        .N_OUT    (2),
        .N_IN     (1),
        .OUT_RESET(8'hA5)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .clk_en_i    (clk_en),
        .aux_adr_i   (aux_adr),
        .aux_dat_i   (aux_dat),
        .aux_we_i    (aux_we),
        .aux_re_i    (aux_re),
        .aux_dat_o   (aux_dat_o),
        .aux_dat_oe_o(aux_dat_oe),
        .port_i      (port_i),
        .port_o      (port_o),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write committed at the next rising edge; returns #1 after that edge
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic en);
        @(negedge clk);
        aux_adr = a;
        aux_dat = d;
        aux_we  = 1'b1;
        clk_en  = en;
        @(posedge clk);
        #1;
        aux_we  = 1'b0;
        clk_en  = 1'b0;
    endtask

    // Combinational read at the current time
    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic o);
        aux_adr = a;
        aux_re  = 1'b1;
        #1;
        d = aux_dat_o;
        o = aux_dat_oe;
        aux_re = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        clk_en  = 1'b0;
        aux_adr = 16'h0000;
        aux_dat = 8'h00;
        aux_we  = 1'b0;
        aux_re  = 1'b0;
        port_i  = 8'h00;

        // Reset state
        tick(2);
        check("rst_port_o", 32'(port_o), 32'h0000A5A5);
        check("rst_irq", 32'(irq), 32'h0);
        aux_adr = 16'h0038;
        #1;
        check("rst_oe_no_re", 32'(aux_dat_oe), 32'h0);
        bus_read(16'h0038, rd, oe);
        check("rst_mask_rd", 32'(rd), 32'h00);
        check("rst_mask_oe", 32'(oe), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // Write / readback
        bus_write(16'h0021, 8'h3C, 1'b1);
        check("wr_out1_port_o", 32'(port_o), 32'h00003CA5);
        bus_read(16'h0021, rd, oe);
        check("rd_out1", 32'(rd), 32'h3C);
        check("rd_out1_oe", 32'(oe), 32'h1);
        bus_read(16'h0020, rd, oe);
        check("rd_out0", 32'(rd), 32'hA5);
        bus_write(16'h0021, 8'h55, 1'b0);
        check("wr_no_clk_en", 32'(port_o), 32'h00003CA5);
        bus_write(16'h0020, 8'h0F, 1'b1);
        check("wr_out0_port_o", 32'(port_o), 32'h00003C0F);

        // Window miss and unmapped offsets
        bus_read(16'h0040, rd, oe);
        check("miss_oe", 32'(oe), 32'h0);
        check("miss_rd", 32'(rd), 32'h00);
        bus_read(16'h0027, rd, oe);
        check("unmapped_rd", 32'(rd), 32'h00);
        check("unmapped_oe", 32'(oe), 32'h1);
        bus_write(16'h0027, 8'hFF, 1'b1);
        check("unmapped_wr", 32'(port_o), 32'h00003C0F);
        bus_write(16'h0022, 8'hFF, 1'b1);
        check("out2_wr_ignored", 32'(port_o), 32'h00003C0F);
        bus_write(16'h0028, 8'hFF, 1'b1);
        bus_read(16'h0028, rd, oe);
        check("in_wr_ignored", 32'(rd), 32'h00);

        // Read during write returns the old value
        @(negedge clk);
        aux_adr = 16'h0020;
        aux_dat = 8'hC3;
        aux_we  = 1'b1;
        clk_en  = 1'b1;
        aux_re  = 1'b1;
        #1;
        check("rdwr_old_value", 32'(aux_dat_o), 32'h0F);
        @(posedge clk);
        #1;
        aux_we = 1'b0;
        clk_en = 1'b0;
        aux_re = 1'b0;
        check("rdwr_commit", 32'(port_o), 32'h00003CC3);

        // Input synchroniser latency: 2 edges
        @(negedge clk);
        port_i = 8'h5A;
        tick(1);
        bus_read(16'h0028, rd, oe);
        check("in_after_1", 32'(rd), 32'h00);
        tick(1);
        bus_read(16'h0028, rd, oe);
        check("in_after_2", 32'(rd), 32'h5A);

`ifdef AUX_GPIO_EDGE_EN
        // Multi-bit capture from the 0x00->0x5A step, then clear all
        tick(1);
        bus_read(16'h0030, rd, oe);
        check("flag_multi", 32'(rd), 32'h5A);
        check("irq_masked_off", 32'(irq), 32'h0);
        @(negedge clk);
        port_i = 8'h00;
        tick(3);
        bus_write(16'h0030, 8'hFF, 1'b1);
        bus_read(16'h0030, rd, oe);
        check("flag_cleared_all", 32'(rd), 32'h00);

        // Edge capture with mask
        bus_write(16'h0038, 8'h01, 1'b1);
        bus_read(16'h0038, rd, oe);
        check("mask_rd", 32'(rd), 32'h01);
        @(negedge clk);
        port_i = 8'h01;
        tick(2);
        check("irq_after_2", 32'(irq), 32'h0);
        tick(1);
        check("irq_after_3", 32'(irq), 32'h1);
        bus_read(16'h0030, rd, oe);
        check("flag0_set", 32'(rd), 32'h01);
        bus_read(16'h0030, rd, oe);
        check("flag_rd_no_clear", 32'(rd), 32'h01);
        bus_write(16'h0030, 8'h01, 1'b1);
        check("irq_after_w1c", 32'(irq), 32'h0);
        bus_read(16'h0030, rd, oe);
        check("flag0_cleared", 32'(rd), 32'h00);

        // Set beats clear on the same edge
        @(negedge clk);
        port_i = 8'h00;
        tick(3);
        @(negedge clk);
        port_i = 8'h01;
        tick(2);
        bus_write(16'h0030, 8'h01, 1'b1);
        bus_read(16'h0030, rd, oe);
        check("set_beats_clear", 32'(rd), 32'h01);
        check("set_beats_clear_irq", 32'(irq), 32'h1);

        // Mask gates irq within one edge
        bus_write(16'h0038, 8'h00, 1'b1);
        check("irq_mask_off", 32'(irq), 32'h0);
        bus_write(16'h0038, 8'h01, 1'b1);
        check("irq_mask_on", 32'(irq), 32'h1);
`else
        // Edge logic absent: irq stays low, FLAG/MASK read zero
        bus_write(16'h0038, 8'hFF, 1'b1);
        @(negedge clk);
        port_i = 8'h00;
        tick(3);
        @(negedge clk);
        port_i = 8'hFF;
        tick(4);
        check("noedge_irq", 32'(irq), 32'h0);
        bus_read(16'h0030, rd, oe);
        check("noedge_flag_rd", 32'(rd), 32'h00);
        bus_read(16'h0038, rd, oe);
        check("noedge_mask_rd", 32'(rd), 32'h00);
`endif

        // Reset in the middle of a write, no clock edge needed
        @(negedge clk);
        aux_adr = 16'h0020;
        aux_dat = 8'h77;
        aux_we  = 1'b1;
        clk_en  = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_port_o", 32'(port_o), 32'h0000A5A5);
        check("midrst_irq", 32'(irq), 32'h0);
        bus_read(16'h0030, rd, oe);
        check("midrst_flag", 32'(rd), 32'h00);
        bus_read(16'h0028, rd, oe);
        check("midrst_in", 32'(rd), 32'h00);
        aux_we = 1'b0;
        clk_en = 1'b0;
        tick(1);
        check("midrst_hold", 32'(port_o), 32'h0000A5A5);
        @(negedge clk);
        reset = 1'b0;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
